// File: rtl/multicycle_pkg.sv
// Shared types and encodings for the multicycle RISC-V controller: state enum,
// opcode constants and datapath select codes.
package multicycle_pkg;

    typedef enum logic [3:0] {
        StFetch    = 4'd0,
        StDecode   = 4'd1,
        StMemAdr   = 4'd2,
        StMemRead  = 4'd3,
        StMemWb    = 4'd4,
        StMemWrite = 4'd5,
        StExecuteR = 4'd6,
        StExecuteI = 4'd7,
        StAluWb    = 4'd8,
        StBeq      = 4'd9,
        StJal      = 4'd10
    } state_t;

    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpRtype  = 7'b0110011;
    localparam logic [6:0] OpItype  = 7'b0010011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpJal    = 7'b1101111;

    localparam logic [1:0] SrcAPc    = 2'b00;
    localparam logic [1:0] SrcAOldPc = 2'b01;
    localparam logic [1:0] SrcARs1   = 2'b10;

    localparam logic [1:0] SrcBRs2  = 2'b00;
    localparam logic [1:0] SrcBImm  = 2'b01;
    localparam logic [1:0] SrcBFour = 2'b10;

    localparam logic [1:0] ResAluOut    = 2'b00;
    localparam logic [1:0] ResReadData  = 2'b01;
    localparam logic [1:0] ResAluResult = 2'b10;

    localparam logic [1:0] AluAdd   = 2'b00;
    localparam logic [1:0] AluSub   = 2'b01;
    localparam logic [1:0] AluFunct = 2'b10;

    function automatic logic is_legal_op(input logic [6:0] op);
        return (op == OpLoad) || (op == OpStore) || (op == OpRtype) ||
               (op == OpItype) || (op == OpBranch) || (op == OpJal);
    endfunction

endpackage

// File: rtl/mc_output_decode.sv
// Combinational state-to-control-word table for the multicycle controller.
module mc_output_decode
    import multicycle_pkg::*;
(
    input  logic [3:0] state,
    output logic       ir_write,
    output logic       adr_src,
    output logic       mem_write,
    output logic       reg_write,
    output logic       pc_update,
    output logic       branch,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] result_src,
    output logic [1:0] alu_op
);

    always_comb begin
        ir_write   = 1'b0;
        adr_src    = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        pc_update  = 1'b0;
        branch     = 1'b0;
        alu_src_a  = SrcAPc;
        alu_src_b  = SrcBRs2;
        result_src = ResAluOut;
        alu_op     = AluAdd;
        case (state)
            StFetch: begin
                ir_write   = 1'b1;
                pc_update  = 1'b1;
                alu_src_b  = SrcBFour;
                result_src = ResAluResult;
            end
            StDecode: begin
                alu_src_a = SrcAOldPc;
                alu_src_b = SrcBImm;
            end
            StMemAdr: begin
                alu_src_a = SrcARs1;
                alu_src_b = SrcBImm;
            end
            StMemRead:  adr_src = 1'b1;
            StMemWb: begin
                result_src = ResReadData;
                reg_write  = 1'b1;
            end
            StMemWrite: begin
                adr_src   = 1'b1;
                mem_write = 1'b1;
            end
            StExecuteR: begin
                alu_src_a = SrcARs1;
                alu_op    = AluFunct;
            end
            StExecuteI: begin
                alu_src_a = SrcARs1;
                alu_src_b = SrcBImm;
                alu_op    = AluFunct;
            end
            StAluWb:    reg_write = 1'b1;
            StBeq: begin
                alu_src_a = SrcARs1;
                alu_op    = AluSub;
                branch    = 1'b1;
            end
            StJal: begin
                alu_src_a = SrcAOldPc;
                alu_src_b = SrcBFour;
                pc_update = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle RISC-V main controller: state register, next-state logic, strobe gating.
// Define MULTICYCLE_CTRL_MEMREADY_EN to stall memory states on mem_ready.
module multicycle_control
    import multicycle_pkg::*;
#(
    parameter int unsigned STATE_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [6:0]         opcode,
    input  logic               zero,
`ifdef MULTICYCLE_CTRL_MEMREADY_EN
    input  logic               mem_ready,
`endif
    output logic               pc_write,
    output logic               ir_write,
    output logic               adr_src,
    output logic               mem_write,
    output logic               reg_write,
    output logic               illegal_instr,
    output logic [1:0]         alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [1:0]         result_src,
    output logic [1:0]         alu_op,
    output logic [STATE_W-1:0] state
);

    state_t state_q, state_d;
    logic   mem_go;
    logic   dec_ir_write, dec_mem_write, dec_reg_write, dec_pc_update, dec_branch;
    logic   pc_update;

`ifdef MULTICYCLE_CTRL_MEMREADY_EN
    assign mem_go = mem_ready;
`else
    assign mem_go = 1'b1;
`endif

    always_comb begin
        state_d = StFetch;
        case (state_q)
            StFetch:    state_d = mem_go ? StDecode : StFetch;
            StDecode: begin
                case (opcode)
                    OpLoad, OpStore: state_d = StMemAdr;
                    OpRtype:         state_d = StExecuteR;
                    OpItype:         state_d = StExecuteI;
                    OpBranch:        state_d = StBeq;
                    OpJal:           state_d = StJal;
                    default:         state_d = StFetch;
                endcase
            end
            StMemAdr:   state_d = opcode[5] ? StMemWrite : StMemRead;
            StMemRead:  state_d = mem_go ? StMemWb : StMemRead;
            StMemWrite: state_d = mem_go ? StFetch : StMemWrite;
            StExecuteR, StExecuteI, StJal: state_d = StAluWb;
            default:    state_d = StFetch;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) state_q <= StFetch;
        else        state_q <= state_d;
    end

    // While in reset the register may not yet hold FETCH, so decode FETCH directly.
    mc_output_decode u_decode (
        .state      (reset ? state_q : StFetch),
        .ir_write   (dec_ir_write),
        .adr_src    (adr_src),
        .mem_write  (dec_mem_write),
        .reg_write  (dec_reg_write),
        .pc_update  (dec_pc_update),
        .branch     (dec_branch),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .result_src (result_src),
        .alu_op     (alu_op)
    );

    // Only the FETCH PC increment waits for memory; the JAL jump does not.
    assign pc_update     = dec_pc_update & (mem_go | (state_q != StFetch));
    assign ir_write      = reset & dec_ir_write & mem_go;
    assign mem_write     = reset & dec_mem_write & mem_go;
    assign reg_write     = reset & dec_reg_write;
    assign pc_write      = reset & (pc_update | (dec_branch & zero));
    assign illegal_instr = reset & (state_q == StDecode) & ~is_legal_op(opcode);
    assign state         = STATE_W'(state_q);

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 The block SHALL have one parameter: STATE_W, default 4, width of the state debug output.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-low reset.
REQ-004 The block SHALL have the following inputs:
- opcode, 7 bits: instruction[6:0] from the instruction register.
- zero, 1 bit: ALU zero flag.
- mem_ready, 1 bit: memory completion; present only with MULTICYCLE_CTRL_MEMREADY_EN.
REQ-005 The block SHALL have the following 1-bit outputs:
- pc_write: load the PC.
- ir_write: load the instruction register.
- adr_src: memory address select; 0 = PC, 1 = ALUOut.
- mem_write: memory write strobe.
- reg_write: register-file write strobe.
- illegal_instr: one-cycle pulse flagging an unsupported opcode.
REQ-006 The block SHALL have the following 2-bit outputs, driving the 2-bit selects of the datapath operand multiplexers:
- alu_src_a: 00 = PC, 01 = oldPC, 10 = rs1 data.
- alu_src_b: 00 = rs2 data, 01 = immediate, 10 = constant 4.
- result_src: 00 = ALUOut, 01 = read data, 10 = ALU result.
- alu_op: 00 = add, 01 = subtract, 10 = funct-decoded.
REQ-007 The block SHALL have output state, STATE_W bits: the current state encoding, for debug.

Function
REQ-008 The block SHALL be a Moore FSM with exactly these states and encodings: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, BEQ=9, JAL=10; codes 11-15 SHALL go to FETCH on the next edge.
REQ-009 The block SHALL make these transitions:
- FETCH -> DECODE.
- DECODE -> MEMADR for opcode 0000011 or 0100011.
- DECODE -> EXECUTER for 0110011, EXECUTEI for 0010011, BEQ for 1100011, JAL for 1101111.
- DECODE -> FETCH for any other opcode, pulsing illegal_instr for that DECODE cycle.
- MEMADR -> MEMREAD if opcode[5]=0, else MEMWRITE.
- MEMREAD -> MEMWB.
- EXECUTER, EXECUTEI and JAL -> ALUWB.
- MEMWB, MEMWRITE, ALUWB and BEQ -> FETCH.
REQ-010 The block SHALL decode every output combinationally from the state register only (except pc_write), and SHALL drive every output not listed for a state to 0/00.
REQ-011 The block SHALL drive these per-state outputs:
- FETCH: ir_write=1, alu_src_a=00, alu_src_b=10, alu_op=00, result_src=10, pc_update=1.
- DECODE: alu_src_a=01, alu_src_b=01.
- MEMADR: alu_src_a=10, alu_src_b=01.
- MEMREAD: adr_src=1.
- MEMWB: result_src=01, reg_write=1.
- MEMWRITE: adr_src=1, mem_write=1.
- EXECUTER: alu_src_a=10, alu_src_b=00, alu_op=10.
- EXECUTEI: alu_src_a=10, alu_src_b=01, alu_op=10.
- ALUWB: reg_write=1.
- BEQ: alu_src_a=10, alu_op=01, branch=1.
- JAL: alu_src_a=01, alu_src_b=10, pc_update=1.
REQ-012 The block SHALL compute pc_write = pc_update OR (branch AND zero), where pc_update and branch are internal signals.
REQ-013 The block SHALL never drive select code 11 on any 2-bit select output.
REQ-014 Without stalls, the block SHALL execute instructions in these cycle counts: lw 5, sw 4, R-type 4, I-type 4, beq 3, jal 4, illegal 2.
REQ-015 The block SHALL assert at most one of mem_write, reg_write and ir_write in any cycle.

Reset
REQ-016 The block SHALL, while reset=0 at a rising clk edge, load state FETCH.
REQ-017 During reset, the block SHALL hold outputs at the FETCH decode, except that ir_write, pc_write, mem_write, reg_write and illegal_instr SHALL be forced to 0.
REQ-018 A reset asserted mid-instruction SHALL abandon that instruction, with no strobe asserted after the reset edge.

Configuration
REQ-019 With MULTICYCLE_CTRL_MEMREADY_EN defined:
- FETCH, MEMREAD and MEMWRITE SHALL hold their state while mem_ready=0.
- ir_write, pc_update and mem_write SHALL be asserted only in the cycle in which mem_ready=1.
REQ-020 With MULTICYCLE_CTRL_MEMREADY_EN undefined, the mem_ready port SHALL be absent and every state SHALL last exactly one cycle.

Structure
REQ-021 Package multicycle_pkg SHALL hold the state enum, the opcode constants, and the alu_src_a, alu_src_b, result_src and alu_op encodings.
REQ-022 Sub-module mc_output_decode SHALL hold the purely combinational state-to-control-word table; the top level SHALL hold the state register and next-state logic.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- Reset low for 2 cycles then high, opcode=0110011 -> state sequence 0,1,6,8,0; reg_write=1 only in state 8.
- opcode=0000011 -> states 0,1,2,3,4; result_src=01 and reg_write=1 in MEMWB; adr_src=1 in MEMREAD.
- opcode=1100011 with zero=1 in BEQ -> pc_write=1 in BEQ; with zero=0 -> pc_write=0 in BEQ; both return to FETCH after 3 cycles.
- opcode=1110011 -> illegal_instr=1 for exactly the DECODE cycle, then FETCH; no write strobes.
- Reset driven low during MEMWRITE -> next state FETCH; mem_write=0 from the reset edge on.
- MEMREADY_EN build, mem_ready=0 for 3 cycles in FETCH -> state held, ir_write=0; mem_ready=1 -> ir_write=1 and pc_write=1 for one cycle, then DECODE.
